stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Time/vitals-driven controller for the post-op stage FSM. Drives its
//  'incremento' advance pulse after a programmable dwell per stage and only
//  while the patient stays stable. Compares incoming sensor samples against
//  the current 'soglia' and raises a sticky alarm on sustained over-threshold.
//  Sits between the sample acquisition path and the stage FSM.
// PARAMETERS
//  MAXB        9   width of sample and soglia
//  STAGE       3   width of stage input
//  DW          16  width of dwell counter
//  DWELL_TICKS 16  ticks spent in a stage before advance (>=1, < 2**DW)
//  ALARM_N     3   consecutive over-threshold samples that trigger alarm (>=1)
//  LAST_STAGE  5   stage code after which no further advance is requested
//  ACK_TO      4   clk cycles to wait for stage change before re-issuing pulse
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  en           in   1      monitoring enable (same signal as stage FSM 'sw')
//  tick         in   1      1-cycle timebase strobe
//  sample_valid in   1      1-cycle qualifier for sample
//  sample       in   MAXB   sensor value, unsigned
//  soglia       in   MAXB   current threshold from stage FSM, unsigned
//  stage        in   STAGE  current stage code from stage FSM
//  alarm_clr    in   1      1-cycle acknowledge that clears alarm
//  incremento   out  1      1-cycle advance request to stage FSM
//  alarm        out  1      sticky over-threshold alarm
//  dwell_cnt    out  DW     ticks elapsed in current stage
//  state_o      out  3      FSM state code, for debug/LEDs
// BEHAVIOUR
//  Reset, synchronous on rst=1: state IDLE; incremento=0, alarm=0,
//  dwell_cnt=0, state_o=0; over-count and ack timer cleared.
//  All outputs are registered.
//  States and codes: IDLE=0, DWELL=1, ADVANCE=2, WAIT=3, ALARM=4.
//  Priority in every state: en=0 > alarm trigger > dwell expiry.
//   en=0 forces IDLE on the next edge and clears all counters. alarm drops.
//  IDLE: when en=1, go to DWELL with dwell_cnt=0.
//  DWELL:
//   - On each tick, dwell_cnt += 1 (saturates at 2**DW-1).
//   - Expiry is tick with dwell_cnt==DWELL_TICKS-1 and stage<LAST_STAGE:
//     go to ADVANCE.
//   - If stage>=LAST_STAGE, stay in DWELL; counting continues.
//  Sample rule, in DWELL, ADVANCE and WAIT: on sample_valid, if
//  sample > soglia (strict), over_cnt += 1; otherwise over_cnt = 0.
//   - When over_cnt reaches ALARM_N, go to ALARM next edge and set alarm=1.
//   - Alarm takes precedence over a simultaneous expiry; no pulse is issued.
//  ADVANCE: incremento=1 for exactly one cycle, latch stage into stage_prev,
//   clear ack timer, go to WAIT.
//  WAIT: incremento=0; ack timer counts clk cycles.
//   - stage != stage_prev: go to DWELL, dwell_cnt=0.
//   - Timer reaches ACK_TO-1 with no change: go to ADVANCE (retry).
//  ALARM: alarm=1, no incremento, dwell_cnt frozen. Samples are ignored.
//   - alarm_clr=1: alarm=0, over_cnt=0, dwell_cnt=0, go to DWELL.
//   - alarm_clr is ignored in all other states.
//  Simultaneous tick + sample_valid in the same cycle: both are processed.
//  incremento is never high on two consecutive cycles.
//  Width rules: the comparator is MAXB-bit unsigned. over_cnt is wide
//   enough for ALARM_N and saturates.
// TESTING
//  T1 rst=1 for 2 clk, en=1 -> all outputs 0 during reset; state_o=1 on the
//     first edge after release.
//  T2 en=1, stage=1, 16 ticks, samples<soglia -> single incremento exactly
//     1 clk after the 16th tick. stage->2 within ACK_TO: dwell_cnt=0.
//  T3 After the pulse, stage held constant -> incremento re-fires every
//     ACK_TO+1 clk until stage changes.
//  T4 soglia=250, samples 251,260,300 -> alarm=1 after the 3rd sample.
//     Samples 251,100,251,251 -> no alarm. alarm_clr=1 -> alarm=0, DWELL.
//  T5 3rd over-sample coincides with 16th tick -> alarm=1, incremento
//     stays 0.
//  T6 stage=5 -> no incremento after 40 ticks. en=0 mid-WAIT -> IDLE
//     next clk, outputs 0.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer
//    Time- and vitals-driven controller that sits between the sample
//    acquisition path and the post-op stage FSM.
//
//    After a programmable dwell in each stage it pulses 'incremento' to
//    request an advance. The request is only made while the patient stays
//    stable. If the stage FSM does not react, the pulse is re-issued.
//
//    Incoming samples are compared against the current 'soglia'. A run of
//    consecutive over-threshold samples latches a sticky alarm, which holds
//    until it is acknowledged.
//
// Ports
//    clk           system clock
//    rst           synchronous, active-high reset
//    en            monitoring enable (same signal as the stage FSM 'sw')
//    tick          1-cycle timebase strobe
//    sample_valid  1-cycle qualifier for sample
//    sample        sensor value, unsigned
//    soglia        current threshold from the stage FSM, unsigned
//    stage         current stage code from the stage FSM
//    alarm_clr     1-cycle alarm acknowledge
//    incremento    1-cycle advance request to the stage FSM (registered)
//    alarm         sticky over-threshold alarm (registered)
//    dwell_cnt     ticks elapsed in the current stage (registered)
//    state_o       FSM state code (registered)
//
// State table
//    state   | meaning
//    IDLE    | monitoring disabled, everything cleared
//    DWELL   | counting ticks in the current stage
//    ADVANCE | incremento high for this cycle, stage snapshot taken
//    WAIT    | waiting for the stage FSM to change stage, retry on timeout
//    ALARM   | sticky alarm raised, waiting for alarm_clr

module stage_sequencer #(
   parameter int MAXB        = 9,
   parameter int STAGE       = 3,
   parameter int DW          = 16,
   parameter int DWELL_TICKS = 16,
   parameter int ALARM_N     = 3,
   parameter int LAST_STAGE  = 5,
   parameter int ACK_TO      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             tick,
   input  logic             sample_valid,
   input  logic [MAXB-1:0]  sample,
   input  logic [MAXB-1:0]  soglia,
   input  logic [STAGE-1:0] stage,
   input  logic             alarm_clr,
   output logic             incremento,
   output logic             alarm,
   output logic [DW-1:0]    dwell_cnt,
   output logic [2:0]       state_o
);

   localparam int OW = $clog2(ALARM_N + 1);
   localparam int AW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DWELL   = 3'd1,
      ADVANCE = 3'd2,
      WAIT    = 3'd3,
      ALARM   = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [DW-1:0]    dwell_nx;
   logic [OW-1:0]    over_cnt, over_nx;
   logic [AW-1:0]    ack_cnt, ack_nx;
   logic [STAGE-1:0] stage_prev, prev_nx;

   logic over_hit;
   logic sample_act;
   logic trig;
   logic expiry;

   always_comb begin
      state_nx   = state;
      dwell_nx   = dwell_cnt;
      over_nx    = over_cnt;
      ack_nx     = ack_cnt;
      prev_nx    = stage_prev;
      over_hit   = sample_valid && (sample > soglia);
      sample_act = (state == DWELL) || (state == ADVANCE) || (state == WAIT);
      trig       = 1'b0;
      expiry     = 1'b0;

      // Samples are only judged while actively monitoring; ALARM freezes
      // the run count until it is acknowledged.
      if (sample_act && sample_valid) begin
         if (over_hit)
            over_nx = (over_cnt == {OW{1'b1}}) ? over_cnt : over_cnt + OW'(1);
         else
            over_nx = '0;
      end
      trig = sample_act && over_hit && (over_cnt >= OW'(ALARM_N - 1));

      case (state)
         IDLE: begin
            if (en) begin
               state_nx = DWELL;
               dwell_nx = '0;
            end
         end
         DWELL: begin
            if (tick && (dwell_cnt != {DW{1'b1}}))
               dwell_nx = dwell_cnt + DW'(1);
            expiry = tick && (dwell_cnt == DW'(DWELL_TICKS - 1)) &&
                     (stage < STAGE'(LAST_STAGE));
            if (trig)
               state_nx = ALARM;
            else if (expiry)
               state_nx = ADVANCE;
         end
         ADVANCE: begin
            prev_nx  = stage;
            ack_nx   = '0;
            state_nx = trig ? ALARM : WAIT;
         end
         WAIT: begin
            if (trig) begin
               state_nx = ALARM;
            end else if (stage != stage_prev) begin
               state_nx = DWELL;
               dwell_nx = '0;
            end else if (ack_cnt == AW'(ACK_TO - 1)) begin
               state_nx = ADVANCE;
            end else begin
               ack_nx = ack_cnt + AW'(1);
            end
         end
         ALARM: begin
            if (alarm_clr) begin
               state_nx = DWELL;
               over_nx  = '0;
               dwell_nx = '0;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      if (!en) begin
         state_nx = IDLE;
         dwell_nx = '0;
         over_nx  = '0;
         ack_nx   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dwell_cnt  <= '0;
         over_cnt   <= '0;
         ack_cnt    <= '0;
         stage_prev <= '0;
         incremento <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state      <= state_nx;
         dwell_cnt  <= dwell_nx;
         over_cnt   <= over_nx;
         ack_cnt    <= ack_nx;
         stage_prev <= prev_nx;
         // Outputs follow the next state so they line up with state_o.
         incremento <= (state_nx == ADVANCE);
         alarm      <= (state_nx == ALARM);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_stage_sequencer;

   localparam int MAXB        = 9;
   localparam int STAGE       = 3;
   localparam int DW          = 16;
   localparam int DWELL_TICKS = 16;
   localparam int ALARM_N     = 3;
   localparam int LAST_STAGE  = 5;
   localparam int ACK_TO      = 4;
   localparam int DMAX        = (1 << DW) - 1;

   logic             clk = 1'b0;
   logic             rst, en, tick, sample_valid, alarm_clr;
   logic [MAXB-1:0]  sample, soglia;
   logic [STAGE-1:0] stage;
   logic             incremento, alarm;
   logic [DW-1:0]    dwell_cnt;
   logic [2:0]       state_o;

   int checks = 0;
   int errors = 0;

   // Reference model: mode follows the documented state codes
   // (0 idle, 1 dwell, 2 advance, 3 wait, 4 alarm).
   int m_mode  = 0;
   int m_dwell = 0;
   int m_run   = 0;   // consecutive over-threshold samples seen
   int m_since = 0;   // clk cycles spent waiting since the last pulse
   int m_snap  = 0;   // stage value captured at the pulse

   stage_sequencer #(
      .MAXB(MAXB), .STAGE(STAGE), .DW(DW), .DWELL_TICKS(DWELL_TICKS),
      .ALARM_N(ALARM_N), .LAST_STAGE(LAST_STAGE), .ACK_TO(ACK_TO)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .tick(tick),
      .sample_valid(sample_valid), .sample(sample), .soglia(soglia),
      .stage(stage), .alarm_clr(alarm_clr),
      .incremento(incremento), .alarm(alarm),
      .dwell_cnt(dwell_cnt), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Apply one clock worth of the documented rules to the model.
   task automatic ref_step();
      int  nm;
      bit  hit, alarm_now, expire;
      nm = m_mode;
      if (rst) begin
         m_mode = 0; m_dwell = 0; m_run = 0; m_since = 0; m_snap = 0;
         return;
      end
      if (!en) begin
         nm = 0; m_dwell = 0; m_run = 0; m_since = 0;
      end else if (m_mode == 0) begin
         nm = 1; m_dwell = 0;
      end else if (m_mode == 4) begin
         if (alarm_clr) begin
            nm = 1; m_run = 0; m_dwell = 0;
         end
      end else begin
         hit = sample_valid && (int'(sample) > int'(soglia));
         if (sample_valid) m_run = hit ? m_run + 1 : 0;
         if (m_run > ALARM_N) m_run = ALARM_N;
         alarm_now = hit && (m_run >= ALARM_N);
         if (m_mode == 1) begin
            expire = tick && (m_dwell == DWELL_TICKS - 1) &&
                     (int'(stage) < LAST_STAGE);
            if (tick && m_dwell < DMAX) m_dwell++;
            nm = alarm_now ? 4 : (expire ? 2 : 1);
         end else if (m_mode == 2) begin
            m_snap = int'(stage); m_since = 0;
            nm = alarm_now ? 4 : 3;
         end else begin
            if (alarm_now) nm = 4;
            else if (int'(stage) != m_snap) begin nm = 1; m_dwell = 0; end
            else if (m_since == ACK_TO - 1) nm = 2;
            else m_since++;
         end
      end
      m_mode = nm;
   endtask

   task automatic step();
      ref_step();
      @(posedge clk); #1;
      chk("state_o",    32'(state_o),    32'(m_mode));
      chk("incremento", 32'(incremento), 32'(m_mode == 2));
      chk("alarm",      32'(alarm),      32'(m_mode == 4));
      chk("dwell_cnt",  32'(dwell_cnt),  32'(m_dwell));
   endtask

   task automatic restart();
      en = 1'b0; step();
      en = 1'b1; step();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; tick = 1'b0; sample_valid = 1'b0;
      sample = '0; soglia = 9'd200; stage = 3'd1; alarm_clr = 1'b0;
      #1;

      // T1: reset held two clocks, DWELL on the first edge after release
      step();
      chk("t1_rst_out", {incremento, alarm, state_o, dwell_cnt}, 0);
      step();
      rst = 1'b0;
      step();
      chk("t1_release_state", 32'(state_o), 1);

      // T2: 16 ticks then exactly one pulse, stage change returns to DWELL
      sample_valid = 1'b1; sample = 9'd50;
      for (int i = 1; i <= DWELL_TICKS; i++) begin
         tick = 1'b1; step();
         if (i < DWELL_TICKS) chk("t2_no_early_pulse", 32'(incremento), 0);
         tick = 1'b0; step();
         if (i == DWELL_TICKS) chk("t2_single_pulse", 32'(incremento), 0);
      end
      sample_valid = 1'b0;
      stage = 3'd2; step();
      chk("t2_back_dwell", 32'(state_o), 1);
      chk("t2_dwell_zero", 32'(dwell_cnt), 0);

      // T3: stage held after pulse -> retry every ACK_TO+1 clocks
      tick = 1'b1;
      for (int i = 0; i < DWELL_TICKS; i++) step();
      tick = 1'b0;
      chk("t3_first_pulse", 32'(incremento), 1);
      for (int k = 1; k <= 3 * (ACK_TO + 1) + 1; k++) begin
         step();
         chk("t3_retry_spacing", 32'(incremento), 32'((k % (ACK_TO + 1)) == 0));
      end
      stage = 3'd3; step();
      chk("t3_exit_dwell", 32'(state_o), 1);

      // T4: three over samples raise alarm; broken run does not
      soglia = 9'd250; sample_valid = 1'b1;
      sample = 9'd251; step();
      sample = 9'd260; step();
      chk("t4_no_alarm_yet", 32'(alarm), 0);
      sample = 9'd300; step();
      chk("t4_alarm_set", 32'(alarm), 1);
      sample_valid = 1'b0; step(); step();
      chk("t4_alarm_sticky", 32'(alarm), 1);
      alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
      chk("t4_alarm_clr", 32'(alarm), 0);
      chk("t4_clr_dwell", 32'(state_o), 1);
      sample_valid = 1'b1;
      sample = 9'd251; step();
      sample = 9'd100; step();
      sample = 9'd251; step();
      sample = 9'd251; step();
      chk("t4_broken_run", 32'(alarm), 0);
      sample = 9'd250; step();
      sample_valid = 1'b0;

      // T5: third over sample on the 16th tick -> alarm wins, no pulse
      restart();
      sample = 9'd251;
      for (int i = 1; i <= DWELL_TICKS; i++) begin
         tick = 1'b1;
         sample_valid = (i >= DWELL_TICKS - ALARM_N + 1);
         step();
      end
      tick = 1'b0; sample_valid = 1'b0;
      chk("t5_alarm", 32'(alarm), 1);
      chk("t5_no_pulse", 32'(incremento), 0);
      step();
      chk("t5_no_late_pulse", 32'(incremento), 0);
      alarm_clr = 1'b1; step(); alarm_clr = 1'b0;

      // T6: last stage never advances; en=0 mid-WAIT returns to IDLE
      restart();
      stage = 3'd5; tick = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         chk("t6_last_stage", 32'(incremento), 0);
      end
      tick = 1'b0;
      restart();
      stage = 3'd1; tick = 1'b1;
      for (int i = 0; i < DWELL_TICKS; i++) step();
      tick = 1'b0;
      step(); step();
      chk("t6_in_wait", 32'(state_o), 3);
      en = 1'b0; step();
      chk("t6_idle_out", {incremento, alarm, state_o, dwell_cnt}, 0);
      en = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rst          = ($urandom_range(0, 499) == 0);
         en           = ($urandom_range(0, 63) != 0);
         tick         = ($urandom_range(0, 2) != 0);
         sample_valid = ($urandom_range(0, 1) == 1);
         sample       = MAXB'($urandom_range(0, 511));
         alarm_clr    = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) soglia = MAXB'($urandom_range(0, 511));
         if (incremento && $urandom_range(0, 3) != 0) stage = stage + 3'd1;
         else if ($urandom_range(0, 99) == 0) stage = STAGE'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
